timer_bank: RTL

//  Parametrised bank of N_CH memory-mapped countdown timers on the CPU peripheral bus
//  (pr_addr/pr_wd/pr_we/pr_rd). Supersedes per-timer instances plus hand-written address

---
 rtl/timer_bank.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of N_CH bus-mapped countdown timers with per-channel IRQ
// Optional prescaler: define TIMER_BANK_PRESCALE_EN to enable CTRL[15:8] PSC.
module timer_bank #(
  parameter int          N_CH      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h7F00,
  parameter int          CH_STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       pr_addr,
  input  logic              pr_we,
  input  logic [31:0]       pr_wd,
  output logic [31:0]       pr_rd,
  output logic [N_CH-1:0]   irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [29:0] L_BASE_W = BASE_ADDR[31:2];
  localparam logic [29:0] L_SPAN_W = 30'(N_CH * CH_STRIDE / 4);

  logic [29:0]     w_woff;
  logic            w_hit;
  logic [1:0]      w_word;
  logic [N_CH-1:0] w_sel;
  logic [31:0]     w_rd_ch [N_CH];

  // Decode on word addresses; each channel window is four words.
  assign w_woff = pr_addr - L_BASE_W;
  assign w_hit  = (pr_addr >= L_BASE_W) && (w_woff < L_SPAN_W);
  assign w_word = w_woff[1:0];

  always_comb begin
    pr_rd = 32'h0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel[i]) pr_rd = w_rd_ch[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic        r_en;
    logic        r_mode;
    logic        r_im;
    logic        r_pend;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    state_t      r_state;

    state_t      w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_pend_set;
    logic        w_en_clr;
    logic        w_tick;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_wr_status;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_rd;

    assign w_sel[g]    = w_hit && (w_woff[29:2] == 28'(g));
    assign w_wr_ctrl   = pr_we && w_sel[g] && (w_word == 2'd0);
    assign w_wr_preset = pr_we && w_sel[g] && (w_word == 2'd1);
    assign w_wr_status = pr_we && w_sel[g] && (w_word == 2'd3);

`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0] r_psc;
    logic [7:0] r_psc_cnt;
    logic [7:0] w_psc_cnt_nxt;

    assign w_tick    = (r_psc_cnt == r_psc);
    assign w_ctrl_rd = {16'h0, r_psc, 4'h0, r_im, 1'b0, r_mode, r_en};
`else
    assign w_tick    = 1'b1;
    assign w_ctrl_rd = {24'h0, 4'h0, r_im, 1'b0, r_mode, r_en};
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_pend_set  = 1'b0;
      w_en_clr    = 1'b0;
`ifdef TIMER_BANK_PRESCALE_EN
      w_psc_cnt_nxt = r_psc_cnt;
`endif
      case (r_state)
        S_IDLE: begin
          if (r_en) w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          w_count_nxt = r_preset;
          w_state_nxt = S_CNT;
`ifdef TIMER_BANK_PRESCALE_EN
          w_psc_cnt_nxt = 8'h0;
`endif
        end
        S_CNT: begin
          if (!r_en) begin
            w_state_nxt = S_IDLE;
          end else begin
`ifdef TIMER_BANK_PRESCALE_EN
            w_psc_cnt_nxt = w_tick ? 8'h0 : r_psc_cnt + 8'h1;
`endif
            if (w_tick) begin
              // PRESET of 0 or 1 both expire on the first counting cycle.
              if (r_count > 32'd1) begin
                w_count_nxt = r_count - 32'd1;
              end else begin
                w_count_nxt = 32'h0;
                w_pend_set  = 1'b1;
                w_state_nxt = S_INT;
              end
            end
          end
        end
        S_INT: begin
          if (r_mode) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_en_clr    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= S_IDLE;
        r_count  <= 32'h0;
        r_preset <= 32'h0;
        r_en     <= 1'b0;
        r_mode   <= 1'b0;
        r_im     <= 1'b0;
        r_pend   <= 1'b0;
`ifdef TIMER_BANK_PRESCALE_EN
        r_psc     <= 8'h0;
        r_psc_cnt <= 8'h0;
`endif
      end else begin
        r_state <= w_state_nxt;
        r_count <= w_count_nxt;
`ifdef TIMER_BANK_PRESCALE_EN
        r_psc_cnt <= w_psc_cnt_nxt;
`endif
        // A bus write to CTRL overrides the one-shot EN auto-clear.
        if (w_wr_ctrl) begin
          r_en   <= pr_wd[0];
          r_mode <= pr_wd[1];
          r_im   <= pr_wd[3];
`ifdef TIMER_BANK_PRESCALE_EN
          r_psc  <= pr_wd[15:8];
`endif
        end else if (w_en_clr) begin
          r_en <= 1'b0;
        end
        if (w_wr_preset) r_preset <= pr_wd;
        if (w_pend_set) begin
          r_pend <= 1'b1;
        end else if (w_wr_status && pr_wd[0]) begin
          r_pend <= 1'b0;
        end
      end
    end

    always_comb begin
      w_rd = 32'h0;
      case (w_word)
        2'd0: w_rd = w_ctrl_rd;
        2'd1: w_rd = r_preset;
        2'd2: w_rd = r_count;
        2'd3: w_rd = {31'h0, r_pend};
        default: w_rd = 32'h0;
      endcase
    end

    assign w_rd_ch[g] = w_rd;
    // Derived from flops only, so async reset drops it immediately.
    assign irq[g] = r_pend & r_im;
  end

endmodule
